jt1943_obj_linebuf: RTL

JT1943_OBJ_LINEBUF -- requirements
Module: jt1943_obj_linebuf

---
 rtl/jt1943_obj_pkg.sv | 19 +
 rtl/jtgng_dual_ram.sv | 28 ++
 rtl/jt1943_obj_linebuf.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jt1943_obj_pkg.sv
// Shared constants, state encoding and pixel helpers for the 1943 object line buffer.
package jt1943_obj_pkg;

    localparam logic [7:0] TRANSP = 8'hFF;
    localparam int         LINE_W = 256;
    localparam int         AW     = 8;
    localparam int         DW     = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } obj_state_t;

    // Colour index 15 of any palette is see-through.
    function automatic logic is_transp(input logic [DW-1:0] pxl);
        return pxl[3:0] == 4'hF;
    endfunction

endpackage

// File: rtl/jtgng_dual_ram.sv
// Two-port RAM with independent write ports and asynchronous reads, so a
// lookup sees every write committed on an earlier clock edge.
module jtgng_dual_ram #(
    parameter int aw = 8,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic [aw-1:0] addr_a,
    input  logic [dw-1:0] data_a,
    input  logic          we_a,
    output logic [dw-1:0] q_a,
    input  logic [aw-1:0] addr_b,
    input  logic [dw-1:0] data_b,
    input  logic          we_b,
    output logic [dw-1:0] q_b
);

    logic [dw-1:0] mem [0:(2**aw)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end

    assign q_a = mem[addr_a];
    assign q_b = mem[addr_b];

endmodule

// File: rtl/jt1943_obj_linebuf.sv
// Double-buffered object line buffer: one bank is drawn while the other is shown
// and erased. Horizontal flip is built only when JT1943_OBJ_FLIP_EN is defined.
//
// state | meaning
// CLEAR | power-up sweep writing TRANSP to every location of both banks
// RUN   | normal draw / display operation, held until reset
module jt1943_obj_linebuf
    import jt1943_obj_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen6,
    input  logic          LHBL,
    input  logic          HINIT,
    input  logic [8:0]    hdump,
    input  logic          flip,
    input  logic          wr_en,
    input  logic [8:0]    wr_addr,
    input  logic [DW-1:0] wr_pxl,
    output logic [DW-1:0] obj_pxl,
    output logic          ready
);

    obj_state_t    state;
    logic [AW-1:0] clr_cnt;
    logic          clearing;
    logic          bank;

    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_pxl;
    logic          s1_bank;

    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_nx;
    logic          rd_bank;
    logic [DW-1:0] rd_q;

    assign clearing = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(LINE_W - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              bank <= 1'b0;
        else if (cen6 && HINIT) bank <= ~bank;
    end

    // Draw stage 1: qualify the request and latch the bank it belongs to, so a
    // write caught by a line toggle still lands in the pre-toggle bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_pxl   <= TRANSP;
            s1_bank  <= 1'b0;
        end else begin
            s1_valid <= wr_en && ready && !wr_addr[8] && !is_transp(wr_pxl);
            s1_addr  <= wr_addr[AW-1:0];
            s1_pxl   <= wr_pxl;
            s1_bank  <= bank;
        end
    end

`ifdef JT1943_OBJ_FLIP_EN
    assign rd_addr_nx = flip ? ~hdump[AW-1:0] : hdump[AW-1:0];
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign rd_addr_nx  = hdump[AW-1:0];
`endif

    // Display: address captured at pixel n, data shown and location erased at n+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_bank  <= 1'b0;
            obj_pxl  <= TRANSP;
        end else if (cen6) begin
            obj_pxl  <= rd_valid ? rd_q : TRANSP;
            rd_valid <= LHBL && !hdump[8] && ready;
            rd_addr  <= rd_addr_nx;
            rd_bank  <= ~bank;
        end
    end

    // Draw stage 2 reads the stored pixel combinationally and commits on the same
    // edge; a same-address write one clk later already sees that commit.
    for (genvar k = 0; k < 2; k++) begin : g_bank
        logic [AW-1:0] addr_a;
        logic [DW-1:0] data_a;
        logic [DW-1:0] q_a;
        logic [DW-1:0] q_b;
        logic          we_a;
        logic          we_b;

        assign addr_a = clearing ? clr_cnt : s1_addr;
        assign data_a = clearing ? TRANSP  : s1_pxl;
        assign we_a   = clearing || (s1_valid && (s1_bank == (k == 1)) && is_transp(q_a));
        assign we_b   = cen6 && rd_valid && (rd_bank == (k == 1));

        jtgng_dual_ram #(.aw(AW), .dw(DW)) u_ram (
            .clk    (clk),
            .addr_a (addr_a),
            .data_a (data_a),
            .we_a   (we_a),
            .q_a    (q_a),
            .addr_b (rd_addr),
            .data_b (TRANSP),
            .we_b   (we_b),
            .q_b    (q_b)
        );
    end

    assign rd_q = rd_bank ? g_bank[1].q_b : g_bank[0].q_b;

endmodule
